// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (start bit, NB_DATA bits LSB first, stop bit).
//
// Ports
//   i_clk        system clock, all state changes on its rising edge
//   i_reset      asynchronous active-low reset
//   i_s_tick     one-cycle oversample enable, 16 per bit period
//   i_rx         serial line, idle high
//   o_data       last received word, held until the next o_rx_done
//   o_rx_done    registered one-clock pulse per completed frame
//   o_frame_err  stop bit sampled low in the last completed frame
module uart_rx #(
  parameter int NB_DATA  = 8,
  parameter int SB_TICK  = 16,
  parameter int NB_COUNT = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err
);

  localparam int NB_N = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_COUNT-1:0] MID_TICK  = NB_COUNT'(7);
  localparam logic [NB_COUNT-1:0] BIT_TICK  = NB_COUNT'(15);
  localparam logic [NB_COUNT-1:0] STOP_TICK = NB_COUNT'(SB_TICK - 1);
  localparam logic [NB_N-1:0]     LAST_BIT  = NB_N'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_next;
  logic [NB_COUNT-1:0] s_cnt, s_cnt_next;
  logic [NB_N-1:0]     n_cnt, n_cnt_next;
  logic [NB_DATA-1:0]  b_reg, b_reg_next;
  logic [NB_DATA-1:0]  data_next;
  logic                ferr_next;
  logic                done_next;

  logic rx_meta, rx_s;

  // Two-flop synchronizer; resets to the idle (high) level so reset
  // release on an idle line never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      s_cnt       <= '0;
      n_cnt       <= '0;
      b_reg       <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_next;
      s_cnt       <= s_cnt_next;
      n_cnt       <= n_cnt_next;
      b_reg       <= b_reg_next;
      o_data      <= data_next;
      o_rx_done   <= done_next;
      o_frame_err <= ferr_next;
    end
  end

  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    b_reg_next = b_reg;
    data_next  = o_data;
    ferr_next  = o_frame_err;
    done_next  = 1'b0;

    unique case (state)
      IDLE: begin
        // Start detection does not wait for a tick.
        if (!rx_s) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (s_cnt == MID_TICK) begin
            if (!rx_s) begin
              state_next = DATA;
              s_cnt_next = '0;
              n_cnt_next = '0;
            end else begin
              // Line high at mid start bit: glitch, drop silently.
              state_next = IDLE;
            end
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (s_cnt == BIT_TICK) begin
            s_cnt_next = '0;
            b_reg_next = {rx_s, b_reg[NB_DATA-1:1]};
            if (n_cnt == LAST_BIT) begin
              state_next = STOP;
            end else begin
              n_cnt_next = n_cnt + 1'b1;
            end
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (s_cnt == STOP_TICK) begin
            state_next = IDLE;
            data_next  = b_reg;
            ferr_next  = ~rx_s;
            done_next  = 1'b1;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       i_clk;
  logic       i_reset;
  logic       i_s_tick;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;

  int n_cmp  = 0;
  int n_fail = 0;

  int         cyc      = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         start_cyc = 0;
  logic       prev_done = 1'b0;
  logic       tick_en   = 1'b1;
  logic [1:0] div       = 2'd0;

  int lat0;
  int lat1;

  uart_rx #(.NB_DATA(8), .SB_TICK(16), .NB_COUNT(4)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_s_tick   (i_s_tick),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Baud tick: one pulse every 4 clocks, frozen while tick_en is low.
  initial begin
    i_s_tick = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      if (tick_en) begin
        div      = div + 2'd1;
        i_s_tick = (div == 2'd3);
      end else begin
        i_s_tick = 1'b0;
      end
    end
  end

  // Monitor: cycle counter, pulse count, pulse width.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_rx_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("pulse_width", 32'(prev_done), 32'd0);
      end
      prev_done = o_rx_done;
    end
  end

  task automatic clocks(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  // One frame of 64 clocks per bit. A bad stop bit is held low for 48
  // clocks and then released high for the rest of the bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int stall_bit, input bit align);
    if (align) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge i_clk);
        if (div == 2'd0) break;
      end
    end else begin
      @(negedge i_clk);
    end
    i_rx = 1'b0;
    start_cyc = cyc;
    clocks(64);
    for (int b = 0; b < 8; b++) begin
      i_rx = d[b];
      if (b == stall_bit) begin
        clocks(32);
        tick_en = 1'b0;
        clocks(100);
        tick_en = 1'b1;
        clocks(32);
      end else begin
        clocks(64);
      end
    end
    if (stop_ok) begin
      i_rx = 1'b1;
      clocks(64);
    end else begin
      i_rx = 1'b0;
      clocks(48);
      i_rx = 1'b1;
      clocks(16);
    end
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    i_reset = 1'b0;
    i_rx    = 1'b1;
    clocks(5);
    check("reset_done", 32'(o_rx_done), 32'd0);
    check("reset_data", 32'(o_data), 32'h00);
    check("reset_ferr", 32'(o_frame_err), 32'd0);
    i_reset = 1'b1;
    clocks(20);
    check("idle_no_pulse", 32'(done_cnt), 32'd0);

    // Single byte 0x01, baseline latency.
    send_frame(8'h01, 1'b1, -1, 1'b1);
    wait_done(1, "timeout_01");
    lat0 = done_cyc - start_cyc;
    check("data_01", 32'(o_data), 32'h01);
    check("ferr_01", 32'(o_frame_err), 32'd0);
    check("latency_range", 32'(lat0 >= 600 && lat0 <= 616), 32'd1);
    clocks(100);
    check("one_pulse_01", 32'(done_cnt), 32'd1);

    // Back-to-back 0xA5 then 0x3C.
    send_frame(8'hA5, 1'b1, -1, 1'b0);
    check("data_A5", 32'(o_data), 32'hA5);
    check("ferr_A5", 32'(o_frame_err), 32'd0);
    send_frame(8'h3C, 1'b1, -1, 1'b0);
    wait_done(3, "timeout_3C");
    check("data_3C", 32'(o_data), 32'h3C);
    check("ferr_3C", 32'(o_frame_err), 32'd0);
    clocks(100);
    check("count_b2b", 32'(done_cnt), 32'd3);

    // Bad stop bit, then a good frame clears the error.
    send_frame(8'h55, 1'b0, -1, 1'b1);
    wait_done(4, "timeout_55");
    check("data_55", 32'(o_data), 32'h55);
    check("ferr_55", 32'(o_frame_err), 32'd1);
    clocks(150);
    check("count_bad_stop", 32'(done_cnt), 32'd4);
    send_frame(8'h0F, 1'b1, -1, 1'b1);
    wait_done(5, "timeout_0F");
    check("data_0F", 32'(o_data), 32'h0F);
    check("ferr_0F", 32'(o_frame_err), 32'd0);

    // Three-tick low glitch on the idle line.
    clocks(50);
    i_rx = 1'b0;
    clocks(12);
    i_rx = 1'b1;
    clocks(300);
    check("glitch_count", 32'(done_cnt), 32'd5);
    check("glitch_data", 32'(o_data), 32'h0F);

    // Reset asserted during data bit 4 of 0xFF.
    @(negedge i_clk);
    i_rx = 1'b0;
    clocks(64);
    i_rx = 1'b1;
    clocks(4 * 64 + 32);
    i_reset = 1'b0;
    clocks(10);
    i_reset = 1'b1;
    clocks(1000);
    check("abort_count", 32'(done_cnt), 32'd5);
    check("abort_data", 32'(o_data), 32'h00);
    check("abort_ferr", 32'(o_frame_err), 32'd0);
    send_frame(8'h81, 1'b1, -1, 1'b1);
    wait_done(6, "timeout_81");
    check("data_81", 32'(o_data), 32'h81);
    clocks(100);
    check("count_81", 32'(done_cnt), 32'd6);

    // Tick stall of 100 clocks during data bit 3.
    send_frame(8'hC3, 1'b1, 3, 1'b1);
    wait_done(7, "timeout_C3");
    lat1 = done_cyc - start_cyc;
    check("data_C3", 32'(o_data), 32'hC3);
    check("stall_latency", 32'(lat1), 32'(lat0 + 100));
    clocks(100);
    check("count_C3", 32'(done_cnt), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "global timeout");
  end

endmodule
